// File: rtl/halftone_frame_sequencer.sv
// Raster-order error-diffusion halftoner with one shared pixel datapath.
// Optional row packing (row_bits/row_valid) when HTPV_ROW_PACK_EN is defined.
module halftone_frame_sequencer #(
  parameter int COLS      = 8,
  parameter int ROWS      = 6,
  parameter int THRESHOLD = 128,
  parameter int W1        = 2,
  parameter int W2        = 8,
  parameter int W3        = 4,
  parameter int W4        = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      pix_in,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic            htpv,
  output logic            htpv_valid,
  output logic [2:0]      row_idx,
  output logic [2:0]      col_idx,
  output logic            busy,
`ifdef HTPV_ROW_PACK_EN
  output logic [COLS-1:0] row_bits,
  output logic            row_valid,
`endif
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t     state;
  logic [2:0] row_q;
  logic [2:0] col_q;
  logic [7:0] rbuf [COLS];
  logic [7:0] left_q;
  logic [7:0] ul_q;

  logic        first_row;
  logic        first_col;
  logic        last_row;
  logic        last_col;
  logic [2:0]  col_p1;
  logic [7:0]  e1;
  logic [7:0]  e2;
  logic [7:0]  e3;
  logic [7:0]  e4;
  logic [11:0] wsum;
  logic [9:0]  e_av;
  logic [9:0]  cpv;
  logic        bit_on;
  logic [7:0]  err;
  logic        accept;

`ifdef HTPV_ROW_PACK_EN
  logic [COLS-1:0] row_sh;
  logic [COLS-1:0] row_nx;
`endif

  // Neighbour selection, weighted error average and thresholding.
  always_comb begin
    first_row = (row_q == 3'd0);
    first_col = (col_q == 3'd0);
    last_row  = (row_q == 3'(ROWS-1));
    last_col  = (col_q == 3'(COLS-1));
    col_p1    = col_q + 3'd1;
    e1 = left_q;
    e2 = (first_row || first_col) ? 8'd0 : ul_q;
    e3 = first_row ? 8'd0 : rbuf[col_q];
    e4 = (first_row || last_col) ? 8'd0 : rbuf[col_p1];
    wsum = 12'(W1) * 12'(e1) + 12'(W2) * 12'(e2)
         + 12'(W3) * 12'(e3) + 12'(W4) * 12'(e4);
    e_av   = 10'(wsum >> 4);
    cpv    = {2'b00, pix_in} + e_av;
    bit_on = (cpv >= 10'(THRESHOLD));
    err    = bit_on ? (cpv[7:0] - 8'd255) : cpv[7:0];
    accept = (state == RUN) && pix_valid && pix_ready;
  end

  // Frame control FSM, error storage and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pix_ready  <= 1'b0;
      htpv       <= 1'b0;
      htpv_valid <= 1'b0;
      row_idx    <= 3'd0;
      col_idx    <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      left_q     <= 8'd0;
      ul_q       <= 8'd0;
      for (int i = 0; i < COLS; i++) rbuf[i] <= 8'd0;
    end else begin
      htpv_valid <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            left_q    <= 8'd0;
            ul_q      <= 8'd0;
            for (int i = 0; i < COLS; i++) rbuf[i] <= 8'd0;
          end
        end
        RUN: begin
          if (accept) begin
            htpv        <= bit_on;
            htpv_valid  <= 1'b1;
            row_idx     <= row_q;
            col_idx     <= col_q;
            ul_q        <= rbuf[col_q];
            rbuf[col_q] <= err;
            if (last_col) begin
              col_q  <= 3'd0;
              left_q <= 8'd0;
              if (last_row) begin
                row_q     <= 3'd0;
                state     <= DONE;
                pix_ready <= 1'b0;
                done      <= 1'b1;
              end else begin
                row_q <= row_q + 3'd1;
              end
            end else begin
              col_q  <= col_p1;
              left_q <= err;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          pix_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef HTPV_ROW_PACK_EN
  assign row_nx = {row_sh[COLS-2:0], bit_on};

  // Pack halftone bits of a row, column 0 landing in the MSB.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_sh    <= '0;
      row_bits  <= '0;
      row_valid <= 1'b0;
    end else begin
      row_valid <= 1'b0;
      if (accept) begin
        row_sh <= row_nx;
        if (last_col) begin
          row_bits  <= row_nx;
          row_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
